fifo_deser: RTL

FIFO_DESER -- requirements
Module: fifo_deser

---
 rtl/fifo_deser_pkg.sv | 14 +
 rtl/fifo_deser_if.sv | 31 +++
 rtl/fifo_deser_ctrl.sv | 45 ++++
 rtl/fifo_deser.sv | 60 ++++++
 4 files changed

// File: rtl/fifo_deser_pkg.sv
// Shared FILL/HOLD state encoding and default word geometry for the pipeline FIFO blocks.
// Pure declarations: no latency, no backpressure of its own.
package fifo_deser_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_DATA_BW  = 4;
  localparam int DEF_NUM_WORD = 4;
  localparam int DEF_CNT_BW   = $clog2(DEF_NUM_WORD);

endpackage

// File: rtl/fifo_deser_if.sv
// Bundle between upstream FIFO, deserializer and downstream beat consumer.
// Wiring only: latency and backpressure belong to the endpoints.
interface fifo_deser_if
  import fifo_deser_pkg::*;
#(
  parameter int DATA_BW  = DEF_DATA_BW,
  parameter int NUM_WORD = DEF_NUM_WORD,
  parameter int CNT_BW   = DEF_CNT_BW
);

  logic                         empty;
  logic [DATA_BW-1:0]           fifo_dout;
  logic                         rd_dout;
  logic                         flush;
  logic                         out_ready;
  logic                         out_valid;
  logic [NUM_WORD*DATA_BW-1:0]  out_data;
  logic [CNT_BW-1:0]            fill_cnt;

  // master is the deserializer; slave is the surrounding environment
  modport master (
    input  empty, fifo_dout, flush, out_ready,
    output rd_dout, out_valid, out_data, fill_cnt
  );

  modport slave (
    output empty, fifo_dout, flush, out_ready,
    input  rd_dout, out_valid, out_data, fill_cnt
  );

endinterface

// File: rtl/fifo_deser_ctrl.sv
// Next-state, next-count and pop-strobe logic for the deserializer; purely combinational.
// Pops only in FILL with data present; HOLD waits for out_ready, flush overrides everything.
module fifo_deser_ctrl
  import fifo_deser_pkg::*;
#(
  parameter int NUM_WORD = DEF_NUM_WORD,
  parameter int CNT_BW   = DEF_CNT_BW
) (
  input  logic              rst,
  input  state_t            state,
  input  logic [CNT_BW-1:0] fill_cnt,
  input  logic              empty,
  input  logic              flush,
  input  logic              out_ready,
  output logic              rd_dout,
  output state_t            state_nxt,
  output logic [CNT_BW-1:0] cnt_nxt
);

  localparam logic [CNT_BW-1:0] LAST_SLOT = CNT_BW'(NUM_WORD - 1);

  always_comb begin
    rd_dout   = !rst && (state == FILL) && !empty && !flush;
    state_nxt = state;
    cnt_nxt   = fill_cnt;
    if (flush) begin
      state_nxt = FILL;
      cnt_nxt   = '0;
    end else if (state == HOLD) begin
      // out_valid is exactly "state is HOLD", so this is the output handshake
      if (out_ready) begin
        state_nxt = FILL;
        cnt_nxt   = '0;
      end
    end else if (rd_dout) begin
      if (fill_cnt == LAST_SLOT) begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = fill_cnt + CNT_BW'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_deser.sv
// Packs NUM_WORD upstream FIFO words into one beat, first word in the LSBs.
// out_valid NUM_WORD cycles after first pop; held beat stalls popping until out_ready.
module fifo_deser
  import fifo_deser_pkg::*;
#(
  parameter int DATA_BW  = DEF_DATA_BW,
  parameter int NUM_WORD = DEF_NUM_WORD,
  parameter int CNT_BW   = DEF_CNT_BW
) (
  input  logic          clk,
  input  logic          rst,
  fifo_deser_if.master  bus
);

  state_t                      state;
  state_t                      state_nxt;
  logic [CNT_BW-1:0]           fill_cnt;
  logic [CNT_BW-1:0]           cnt_nxt;
  logic                        out_valid;
  logic [NUM_WORD*DATA_BW-1:0] out_data;
  logic                        pop;

  fifo_deser_ctrl #(
    .NUM_WORD (NUM_WORD),
    .CNT_BW   (CNT_BW)
  ) u_ctrl (
    .rst       (rst),
    .state     (state),
    .fill_cnt  (fill_cnt),
    .empty     (bus.empty),
    .flush     (bus.flush),
    .out_ready (bus.out_ready),
    .rd_dout   (pop),
    .state_nxt (state_nxt),
    .cnt_nxt   (cnt_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      fill_cnt  <= cnt_nxt;
      // registered from next state so out_valid never sees out_ready combinationally
      out_valid <= (state_nxt == HOLD);
      if (pop) begin
        out_data[int'(fill_cnt)*DATA_BW +: DATA_BW] <= bus.fifo_dout;
      end
    end
  end

  assign bus.rd_dout   = pop;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.fill_cnt  = fill_cnt;

endmodule
